// File: rtl/dvm_pkg.sv
// Shared constants, tap-select type and helpers for the dvm_divider clock divider.
package dvm_pkg;

   localparam int DVM_WIDTH_DEF = 32;
   localparam int SEL_DEFAULT   = 1;

   typedef logic [4:0] tap_sel_t;

   // A select of zero or one pointing past the top tap falls back to SEL_DEFAULT.
   function automatic logic sel_in_range(input tap_sel_t sel, input int width);
      return (sel != '0) && (int'(sel) <= width);
   endfunction

endpackage

// File: rtl/dvm_divider_if.sv
// Bus between a dvm_divider and its user: control inputs plus divided-clock outputs.
interface dvm_divider_if
   import dvm_pkg::*;
#(
   parameter int WIDTH = DVM_WIDTH_DEF
);

   logic             en;
   tap_sel_t         sel;
   logic [WIDTH:1]   myclk;
   logic             clk_out;
   logic             tc;

   modport master (
      output en,
      output sel,
      input  myclk,
      input  clk_out,
      input  tc
   );

   modport slave (
      input  en,
      input  sel,
      output myclk,
      output clk_out,
      output tc
   );

endinterface

// File: rtl/dvm_tap_mux.sv
// Registered tap selector: clk_out follows myclk[sel] one edge late.
module dvm_tap_mux
   import dvm_pkg::*;
#(
   parameter int WIDTH = DVM_WIDTH_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  tap_sel_t        sel,
   input  logic [WIDTH:1]  myclk,
   output logic            clk_out
);

   logic [WIDTH:1] tap_hit;
   logic           tap_next;
   logic           clk_out_reg;

   // Compare at 6 bits so a 32-tap build never aliases tap 32 onto sel=0.
   generate
      for (genvar gi = 1; gi <= WIDTH; gi++) begin : g_hit
         assign tap_hit[gi] = myclk[gi] & ({1'b0, sel} == 6'(gi));
      end
   endgenerate

   always_comb begin
      tap_next = myclk[SEL_DEFAULT];
      if (sel_in_range(sel, WIDTH)) begin
         tap_next = |tap_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_out_reg <= 1'b0;
      end else begin
         clk_out_reg <= tap_next;
      end
   end

   assign clk_out = clk_out_reg;

endmodule

// File: rtl/dvm_divider.sv
// Binary ripple-free clock divider with terminal-count pulse and optional tap output.
// Tap select / clk_out register are built only when DVM_TAP_EN is defined.
module dvm_divider
   import dvm_pkg::*;
#(
   parameter int               WIDTH   = DVM_WIDTH_DEF,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   dvm_divider_if.slave  bus
);

   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic             wrap_reg;
   logic             wrap_next;
   logic             tc_reg;
   logic             tc_next;
   logic [WIDTH:1]   myclk;

   // wrap_reg marks "the last enabled edge rolled over"; tc fires on the next enabled edge.
   always_comb begin
      cnt_next  = cnt_reg;
      wrap_next = 1'b0;
      tc_next   = 1'b0;
      if (bus.en) begin
         cnt_next  = cnt_reg + 1'b1;
         wrap_next = &cnt_reg;
         tc_next   = wrap_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg  <= RST_VAL;
         wrap_reg <= 1'b0;
         tc_reg   <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         wrap_reg <= wrap_next;
         tc_reg   <= tc_next;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
         assign myclk[gi+1] = cnt_reg[gi];
      end
   endgenerate

   assign bus.myclk = myclk;
   assign bus.tc    = tc_reg;

`ifdef DVM_TAP_EN
   dvm_tap_mux #(
      .WIDTH   (WIDTH)
   ) u_tap (
      .clk     (clk),
      .rst     (rst),
      .sel     (bus.sel),
      .myclk   (myclk),
      .clk_out (bus.clk_out)
   );
`else
   logic unused_sel;
   assign unused_sel  = ^bus.sel;
   assign bus.clk_out = 1'b0;
`endif

endmodule

// File: tb/tb_dvm_divider.sv
// Directed bench for dvm_divider: a 6-bit instance (main) and a 4-bit RST_VAL=14 instance (wrap).
module tb_dvm_divider;
   import dvm_pkg::*;

   localparam int W_A = 6;
   localparam int W_B = 4;
   localparam int RST_B = 14;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   dvm_divider_if #(.WIDTH(W_A)) bus_a ();
   dvm_divider_if #(.WIDTH(W_B)) bus_b ();

   dvm_divider #(.WIDTH(W_A), .RST_VAL(6'd0)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a.slave)
   );

   dvm_divider #(.WIDTH(W_B), .RST_VAL(4'd14)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b.slave)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Tap rule: sel picks myclk[sel]; sel=0 or past the top tap picks myclk[1].
   function automatic bit tap_model(input int cnt, input int sel, input int w);
`ifdef DVM_TAP_EN
      int k;
      k = (sel == 0 || sel > w) ? 1 : sel;
      return bit'((cnt >> (k - 1)) & 1);
`else
      return 1'b0;
`endif
   endfunction

   // Behavioural model: integer count mod 2^W, a one-cycle-late wrap event for tc, tap sampled per edge.
   int ma_cnt, mb_cnt;
   bit ma_wrapped, mb_wrapped, ma_tc, mb_tc, ma_clk, mb_clk, ma_valid, mb_valid;

   always @(posedge clk) begin
      if (rst_a) begin
         ma_cnt <= 0; ma_wrapped <= 0; ma_tc <= 0; ma_clk <= 0; ma_valid <= 1;
      end else begin
         ma_clk <= tap_model(ma_cnt, int'(bus_a.sel), W_A);
         if (bus_a.en) begin
            ma_cnt     <= (ma_cnt + 1) % (1 << W_A);
            ma_tc      <= ma_wrapped;
            ma_wrapped <= ((ma_cnt + 1) % (1 << W_A)) == 0;
         end else begin
            ma_tc <= 0; ma_wrapped <= 0;
         end
      end
   end

   always @(posedge clk) begin
      if (rst_b) begin
         mb_cnt <= RST_B; mb_wrapped <= 0; mb_tc <= 0; mb_clk <= 0; mb_valid <= 1;
      end else begin
         mb_clk <= tap_model(mb_cnt, int'(bus_b.sel), W_B);
         if (bus_b.en) begin
            mb_cnt     <= (mb_cnt + 1) % (1 << W_B);
            mb_tc      <= mb_wrapped;
            mb_wrapped <= ((mb_cnt + 1) % (1 << W_B)) == 0;
         end else begin
            mb_tc <= 0; mb_wrapped <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (ma_valid) begin
         check("a_myclk_model", bus_a.myclk, ma_cnt);
         check("a_tc_model", bus_a.tc, ma_tc);
         check("a_clk_out_model", bus_a.clk_out, ma_clk);
      end
      if (mb_valid) begin
         check("b_myclk_model", bus_b.myclk, mb_cnt);
         check("b_tc_model", bus_b.tc, mb_tc);
         check("b_clk_out_model", bus_b.clk_out, mb_clk);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int tog [1:3];
      int hi  [1:3];
      logic [W_A:1] prev;
      int sels [4];
      int k;
      bit hit;

      rst_a = 1; rst_b = 1;
      bus_a.en = 1; bus_a.sel = '0;
      bus_b.en = 1; bus_b.sel = '0;

      // Reset held three edges on A while B demonstrates the 14,15,0 wrap and delayed tc.
      step; check("a_rst0", bus_a.myclk, 0); check("a_rst_clk_out", bus_a.clk_out, 0);
            check("b_rstval", bus_b.myclk, 14); check("b_rst_tc", bus_b.tc, 0);
      rst_b = 0;
      step; check("a_rst1", bus_a.myclk, 0); check("b_15", bus_b.myclk, 15);
      step; check("a_rst2", bus_a.myclk, 0); check("a_rst_tc", bus_a.tc, 0);
            check("b_wrap0", bus_b.myclk, 0); check("b_tc_at0", bus_b.tc, 0);
      rst_a = 0;
      step; check("a_first1", bus_a.myclk, 1); check("b_1", bus_b.myclk, 1); check("b_tc_pulse", bus_b.tc, 1);
      step; check("a_first2", bus_a.myclk, 2); check("b_tc_end", bus_b.tc, 0);
      step; check("a_first3", bus_a.myclk, 3);
      bus_b.en = 0;

      // Enable hold at 7.
      repeat (4) step;
      check("a_at7", bus_a.myclk, 7);
      bus_a.en = 0;
      for (int i = 0; i < 5; i++) begin
         step; check("a_hold7", bus_a.myclk, 7); check("a_hold_tc", bus_a.tc, 0);
      end
      bus_a.en = 1;
      step; check("a_resume8", bus_a.myclk, 8);

      // Reset wins over enable at 9.
      step; check("a_at9", bus_a.myclk, 9);
      rst_a = 1;
      step; check("a_prec_cnt", bus_a.myclk, 0); check("a_prec_clk_out", bus_a.clk_out, 0);
            check("a_prec_tc", bus_a.tc, 0);
      rst_a = 0;

      // Free-run 64 cycles: toggle counts give the periods, high counts the duty.
      for (int b = 1; b <= 3; b++) begin tog[b] = 0; hi[b] = 0; end
      prev = bus_a.myclk;
      for (int i = 0; i < 64; i++) begin
         step;
         for (int b = 1; b <= 3; b++) begin
            if (bus_a.myclk[b] != prev[b]) tog[b]++;
            if (bus_a.myclk[b]) hi[b]++;
         end
         prev = bus_a.myclk;
      end
      check("a_tog1", tog[1], 64); check("a_tog2", tog[2], 32); check("a_tog3", tog[3], 16);
      check("a_duty1", hi[1], 32); check("a_duty2", hi[2], 32); check("a_duty3", hi[3], 32);
      check("a_run_wrap", bus_a.myclk, 0); check("a_run_tc0", bus_a.tc, 0);
      step; check("a_run_tc1", bus_a.tc, 1); check("a_run_1", bus_a.myclk, 1);
      step; check("a_run_tc2", bus_a.tc, 0);

      // Tap selection; a new sel is sampled on the very next edge.
      sels = '{2, 0, 7, 6};
      for (int s = 0; s < 4; s++) begin
         bus_a.sel = tap_sel_t'(sels[s]);
         k = (sels[s] == 0 || sels[s] > W_A) ? 1 : sels[s];
         for (int i = 0; i < 6; i++) begin
            prev = bus_a.myclk;
            step;
`ifdef DVM_TAP_EN
            check($sformatf("a_tap_sel%0d", sels[s]), bus_a.clk_out, prev[k]);
`else
            check($sformatf("a_tap_off_sel%0d", sels[s]), bus_a.clk_out, 0);
`endif
         end
      end
      bus_a.sel = '0;

      // Reset right after a wrap must cancel the pending tc.
      hit = 0;
      for (int i = 0; i < 70 && !hit; i++) begin
         if (bus_a.myclk == 6'd63) hit = 1;
         else step;
      end
      check("a_reach63", hit, 1);
      step; check("a_wrap_again", bus_a.myclk, 0);
      rst_a = 1;
      step; check("a_mid_rst_tc", bus_a.tc, 0); check("a_mid_rst_cnt", bus_a.myclk, 0);
      rst_a = 0;
      step; check("a_no_pending_tc", bus_a.tc, 0); check("a_after_rst1", bus_a.myclk, 1);

      step;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dvm_divider.md
DVM_DIVIDER -- requirements
Module: dvm_divider

Interface
REQ-001 Parameter WIDTH, default 32, number of divider stages (counter bits); legal range 2..32.
REQ-002 Parameter RST_VAL, default 0, counter value loaded on reset (WIDTH bits).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; counter holds while low.
REQ-006 sel  input  5  tap select for clk_out; index into myclk, 1-based.
REQ-007 myclk  output  WIDTH (bits [WIDTH:1])  divided clocks; myclk[i] has period 2^i clk cycles.
REQ-008 clk_out  output  1  registered copy of the selected tap myclk[sel].
REQ-009 tc  output  1  terminal-count pulse, one clk cycle wide.

Function
REQ-010 Internal WIDTH-bit up-counter cnt; myclk[i] SHALL equal cnt bit i-1, combinationally, with no extra register stage.
REQ-011 On each rising clk edge with rst=0 and en=1, cnt SHALL increment by 1, modulo 2^WIDTH.
REQ-012 With en=0, cnt, myclk and tc SHALL hold; tc SHALL be 0.
REQ-013 Wrap: all-ones plus 1 SHALL give all-zeros; there is no saturation.
REQ-014 tc SHALL be 1 in exactly the cycle after the counter wraps to 0 (registered, 1-cycle latency) and 0 otherwise.
REQ-015 myclk[1] SHALL toggle every enabled cycle (clk/2); myclk[2] every 2 cycles (clk/4); myclk[i] every 2^(i-1) cycles; all taps SHALL have 50% duty.
REQ-016 clk_out SHALL be registered: clk_out at edge n+1 equals myclk[sel] sampled at edge n.
REQ-017 sel=0 or sel>WIDTH SHALL select myclk[1].
REQ-018 A sel change SHALL take effect on the next edge; no glitch suppression is required.
REQ-019 If rst and en are both high, rst SHALL win.

Reset
REQ-020 While rst=1 at a rising edge: cnt<=RST_VAL, clk_out<=0, tc<=0.
REQ-021 Reset mid-count SHALL discard the count, with no pending tc.
REQ-022 The first increment SHALL occur on the first edge with rst=0 and en=1.

Configuration
REQ-023 The macro DVM_TAP_EN SHALL control the tap logic.
REQ-024 With DVM_TAP_EN defined, the sel mux and the clk_out register SHALL be present as specified.
REQ-025 With DVM_TAP_EN undefined, sel SHALL be ignored and clk_out tied to 0.
REQ-026 The port list SHALL be identical in both builds.

Structure
REQ-027 Package dvm_pkg SHALL hold DVM_WIDTH_DEF=32, the 5-bit tap-select typedef and the SEL_DEFAULT=1 constant.
REQ-028 Sub-module dvm_tap_mux SHALL implement the registered tap select (REQ-016 to REQ-018).
REQ-029 The counter and tc logic SHALL stay in dvm_divider.

Verification
REQ-030 Reset: rst=1 for 3 cycles, then low, en=1 -> myclk=0 during reset; myclk=1,2,3 on the next three edges.
REQ-031 Division: free-run 64 cycles -> myclk[1] period 2 cycles, myclk[2] period 4, myclk[3] period 8, all at 50% duty.
REQ-032 Enable: en=0 for 5 cycles at count 7 -> myclk stays 7 and tc stays 0; the count resumes at 8.
REQ-033 Wrap: WIDTH=4, RST_VAL=14, en=1 -> count 14,15,0; tc=1 exactly one cycle after count 0.
REQ-034 Tap: sel=2 after 32 cycles (DVM_TAP_EN defined) -> clk_out follows myclk[2] delayed one cycle; sel=0 gives myclk[1].
REQ-035 Precedence: rst=1 and en=1 at count 9 -> count 0 next edge and clk_out=0; in the DVM_TAP_EN-undefined build clk_out stays 0 throughout.
